// File: rtl/dbb_rd_resp_slave.sv
// DBB read-channel responder: queues AR requests and returns in-order R bursts
// whose lanes carry an address-derived pattern. Optional stalls: DBB_RD_RESP_STALL_EN.
module dbb_rd_resp_slave #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 512,
  parameter int ALEN_WIDTH   = 4,
  parameter int ASIZE_WIDTH  = 3,
  parameter int ABURST_WIDTH = 2,
  parameter int AID_WIDTH    = 8,
  parameter int RDEPTH       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arvalid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [ALEN_WIDTH-1:0]   arlen,
  input  logic [ASIZE_WIDTH-1:0]  arsize,
  input  logic [ABURST_WIDTH-1:0] arburst,
  input  logic [AID_WIDTH-1:0]    arid,
  output logic                    arready,
  output logic                    rvalid,
  output logic                    rlast,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [AID_WIDTH-1:0]    rid,
  input  logic                    rready,
  output logic                    busy
);
  localparam int PW    = $clog2(RDEPTH);
  localparam int LANES = DATA_WIDTH / 32;

  typedef struct packed {
    logic [AID_WIDTH-1:0]    id;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ALEN_WIDTH-1:0]   len;
    logic [ASIZE_WIDTH-1:0]  size;
    logic [ABURST_WIDTH-1:0] burst;
  } ar_t;

  typedef enum logic {IDLE, BURST} state_t;

  // AR queue
  ar_t           mem [RDEPTH];
  ar_t           head;
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop, ready_q;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign arready = ready_q & ~full;
  assign push    = arvalid & arready;
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr[PW-1:0]] <= ar_t'{arid, araddr, arlen, arsize, arburst};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      ready_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Burst engine
  state_t                  state, nxt;
  logic [ADDR_WIDTH-1:0]   b_addr, nxt_addr, src_addr;
  logic [ALEN_WIDTH-1:0]   b_len, cnt, cnt_inc;
  logic [ASIZE_WIDTH-1:0]  b_size;
  logic [ABURST_WIDTH-1:0] b_burst;
  logic                    adv, rlast_q, fire;
  logic [LANES-1:0][31:0]  rdata_q;

  assign fire     = rvalid & rready;
  assign cnt_inc  = cnt + ALEN_WIDTH'(1);
  assign nxt_addr = (b_burst == '0) ? b_addr : b_addr + (ADDR_WIDTH'(1) << b_size);
  assign src_addr = pop ? head.addr : nxt_addr;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    pop = 1'b0;
    adv = 1'b0;
    case (state)
      IDLE:
        if (!empty) begin
          pop = 1'b1;
          nxt = BURST;
        end
      BURST:
        if (fire) begin
          // Last beat chains straight into the next queued burst when one exists.
          if (cnt == b_len) begin
            if (!empty) pop = 1'b1;
            else        nxt = IDLE;
          end else begin
            adv = 1'b1;
          end
        end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_addr  <= '0;
      b_len   <= '0;
      b_size  <= '0;
      b_burst <= '0;
      cnt     <= '0;
      rid     <= '0;
      rlast_q <= 1'b0;
    end else if (pop) begin
      b_addr  <= head.addr;
      b_len   <= head.len;
      b_size  <= head.size;
      b_burst <= head.burst;
      cnt     <= '0;
      rid     <= head.id;
      rlast_q <= (head.len == '0);
    end else if (adv) begin
      b_addr  <= nxt_addr;
      cnt     <= cnt_inc;
      rlast_q <= (cnt_inc == b_len);
    end
  end

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)          rdata_q[k] <= '0;
        else if (pop || adv) rdata_q[k] <= src_addr[31:0] + 32'(4 * k);
    end
  endgenerate

  assign rdata = rdata_q;
  assign rlast = rlast_q & (state == BURST);
  assign busy  = ~empty | (state == BURST);

`ifdef DBB_RD_RESP_STALL_EN
  logic [7:0] lfsr;
  logic       shown_q;

  // shown_q marks a beat already presented and not yet taken; it must stay up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr    <= 8'hA5;
      shown_q <= 1'b0;
    end else begin
      lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      shown_q <= rvalid & ~rready;
    end
  end

  assign rvalid = (state == BURST) & (shown_q | (lfsr[1:0] != 2'b00));
`else
  assign rvalid = (state == BURST);
`endif

endmodule
